// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code sequencer: pops bytes from the receiver FIFO, strips F0/E0 prefixes,
// tracks modifiers, reads the make2ascii LUT and hands one key event per sequence downstream.
module ps2_scan_sequencer #(
    parameter int unsigned LUT_LAT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ready,
    input  logic [7:0]       scan_data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       lut_addr,
    input  logic [7:0]       lut_q,
    output logic             key_valid,
    input  logic             key_ack,
    output logic [7:0]       key_code,
    output logic [7:0]       key_ascii,
    output logic             key_break,
    output logic             key_ext,
    output logic             shift,
    output logic             ctrl,
    output logic             caps,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_sticky
);

    typedef enum logic [2:0] {StIdle, StPop, StSettle, StLook, StEmit} state_e;

    localparam logic [1:0] LatLast = 2'(LUT_LAT);

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d, held_q, held_d, addr_q, addr_d;
    logic [7:0]       code_q, code_d, ascii_q, ascii_d;
    logic             brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
    logic             brk_q, brk_d, ext_q, ext_d;
    logic             shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       lat_q, lat_d;

    logic       is_shift, is_ctrl, is_caps, is_mod, is_make;
    logic       shift_new, ctrl_new, caps_new;
    logic [7:0] ascii_new;

    assign is_shift  = (byte_q == 8'h12) || (byte_q == 8'h59);
    assign is_ctrl   = (byte_q == 8'h14);
    assign is_caps   = (byte_q == 8'h58);
    assign is_mod    = is_shift || is_ctrl || is_caps;
    assign is_make   = !brk_pend_q;
    assign shift_new = is_shift ? is_make : shift_q;
    assign ctrl_new  = is_ctrl ? is_make : ctrl_q;
    // Auto-repeat makes of caps lock arrive with held_q already 0x58 and must not toggle.
    assign caps_new  = caps_q ^ (is_caps && is_make && (held_q != 8'h58));

    always_comb begin
        if (ext_pend_q) begin
            ascii_new = 8'h00;
        end else if ((shift_new ^ caps_new) && (lut_q >= 8'h61) && (lut_q <= 8'h7a)) begin
            ascii_new = lut_q - 8'h20;
        end else begin
            ascii_new = lut_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        held_d     = held_q;
        addr_d     = addr_q;
        code_d     = code_q;
        ascii_d    = ascii_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        caps_d     = caps_q;
        count_d    = count_q;
        lat_d      = lat_q;
        ovf_d      = ovf_q | overflow;

        unique case (state_q)
            StIdle: begin
                if (ready) begin
                    byte_d  = scan_data;
                    state_d = StPop;
                end
            end
            StPop: state_d = StSettle;
            StSettle: begin
                if (byte_q == 8'hf0) begin
                    brk_pend_d = 1'b1;
                    state_d    = StIdle;
                end else if (byte_q == 8'he0) begin
                    ext_pend_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    addr_d  = byte_q;
                    lat_d   = 2'd0;
                    state_d = StLook;
                end
            end
            StLook: begin
                if (lat_q == LatLast) begin
                    shift_d = shift_new;
                    ctrl_d  = ctrl_new;
                    caps_d  = caps_new;
                    ascii_d = ascii_new;
                    if (is_make) begin
                        if (!is_mod && (byte_q != held_q)) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        held_d = byte_q;
                    end else if (byte_q == held_q) begin
                        held_d = 8'h00;
                    end
                    code_d     = byte_q;
                    brk_d      = brk_pend_q;
                    ext_d      = ext_pend_q;
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                    state_d    = StEmit;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StEmit: begin
                if (key_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= StIdle;
            byte_q     <= 8'h00;
            held_q     <= 8'h00;
            addr_q     <= 8'h00;
            code_q     <= 8'h00;
            ascii_q    <= 8'h00;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            caps_q     <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            lat_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            held_q     <= held_d;
            addr_q     <= addr_d;
            code_q     <= code_d;
            ascii_q    <= ascii_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            caps_q     <= caps_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            lat_q      <= lat_d;
        end
    end

    assign nextdata_n  = (state_q != StPop);
    assign key_valid   = (state_q == StEmit);
    assign lut_addr    = addr_q;
    assign key_code    = code_q;
    assign key_ascii   = ascii_q;
    assign key_break   = brk_q;
    assign key_ext     = ext_q;
    assign shift       = shift_q;
    assign ctrl        = ctrl_q;
    assign caps        = caps_q;
    assign press_count = count_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: a FIFO and LUT model feed the DUT, a byte-level
// reference model predicts key events, a negedge monitor compares and acknowledges them.
module tb_ps2_scan_sequencer;

    localparam int unsigned LUT_LAT = 1;
    localparam int unsigned CNT_W   = 8;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] ascii;
        logic       brk;
        logic       ext;
        logic       shift;
        logic       ctrl;
        logic       caps;
        logic [7:0] count;
    } ev_t;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             ready = 1'b0;
    logic [7:0]       scan_data = 8'h00;
    logic             overflow = 1'b0;
    logic             nextdata_n;
    logic [7:0]       lut_addr;
    logic [7:0]       lut_q;
    logic             key_valid;
    logic             key_ack = 1'b0;
    logic [7:0]       key_code, key_ascii;
    logic             key_break, key_ext, shift, ctrl, caps;
    logic [CNT_W-1:0] press_count;
    logic             ovf_sticky;

    int         vectors = 0;
    int         miscompares = 0;
    int         pops = 0;
    bit         auto_ack = 1'b1;
    bit         seen = 1'b0;
    bit         prev_low = 1'b0;
    logic [7:0] fifo[$];
    ev_t        exp_q[$];
    logic [7:0] lut_pipe[LUT_LAT];

    logic       m_brk, m_ext, m_shift, m_ctrl, m_caps;
    logic [7:0] m_held, m_count;

    ps2_scan_sequencer #(.LUT_LAT(LUT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .ready(ready), .scan_data(scan_data), .overflow(overflow),
        .nextdata_n(nextdata_n), .lut_addr(lut_addr), .lut_q(lut_q), .key_valid(key_valid),
        .key_ack(key_ack), .key_code(key_code), .key_ascii(key_ascii), .key_break(key_break),
        .key_ext(key_ext), .shift(shift), .ctrl(ctrl), .caps(caps),
        .press_count(press_count), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut_fn(input logic [7:0] a);
        case (a)
            8'h1c:   return 8'h61;
            8'h32:   return 8'h62;
            8'h16:   return 8'h31;
            8'h75:   return 8'h38;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        lut_pipe[0] <= lut_fn(lut_addr);
        for (int i = 1; i < LUT_LAT; i++) lut_pipe[i] <= lut_pipe[i-1];
    end
    assign lut_q = lut_pipe[LUT_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_shift = 0; m_ctrl = 0; m_caps = 0;
        m_held = 8'h00; m_count = 8'h00;
    endtask

    // Queue a byte into the receiver FIFO and predict any event it completes.
    task automatic send(input logic [7:0] b);
        ev_t e;
        logic mod;
        fifo.push_back(b);
        if (b == 8'hf0) m_brk = 1;
        else if (b == 8'he0) m_ext = 1;
        else begin
            mod = (b == 8'h12) || (b == 8'h59) || (b == 8'h14) || (b == 8'h58);
            if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
            if (b == 8'h14) m_ctrl = !m_brk;
            if (b == 8'h58 && !m_brk && m_held != 8'h58) m_caps = !m_caps;
            e.ascii = lut_fn(b);
            if (m_ext) e.ascii = 8'h00;
            else if ((m_shift ^ m_caps) && e.ascii >= 8'h61 && e.ascii <= 8'h7a)
                e.ascii = e.ascii - 8'h20;
            if (!m_brk) begin
                if (!mod && b != m_held) m_count = m_count + 8'd1;
                m_held = b;
            end else if (b == m_held) m_held = 8'h00;
            e.code = b; e.brk = m_brk; e.ext = m_ext;
            e.shift = m_shift; e.ctrl = m_ctrl; e.caps = m_caps; e.count = m_count;
            m_brk = 0; m_ext = 0;
            exp_q.push_back(e);
        end
    endtask

    // Receiver FIFO model: pop on the strobe, present the new head shortly after.
    always @(negedge clk) begin
        if (!nextdata_n) begin
            check("pop_ready", 32'(fifo.size() != 0), 1);
            check("pop_single", 32'(prev_low), 0);
            if (fifo.size() != 0) void'(fifo.pop_front());
            pops++;
        end
        prev_low = !nextdata_n;
        #1;
        ready     = (fifo.size() != 0);
        scan_data = ready ? fifo[0] : 8'h00;
    end

    // Event monitor: compare once per event, then ack if allowed.
    always @(negedge clk) begin
        ev_t e;
        if (key_ack) begin
            key_ack = 1'b0;
        end else if (key_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("spurious_event", 32'(key_code), 32'hffff);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_code", 32'(key_code), 32'(e.code));
                    check("ev_ascii", 32'(key_ascii), 32'(e.ascii));
                    check("ev_break", 32'(key_break), 32'(e.brk));
                    check("ev_ext", 32'(key_ext), 32'(e.ext));
                    check("ev_mods", 32'({shift, ctrl, caps}), 32'({e.shift, e.ctrl, e.caps}));
                    check("ev_count", 32'(press_count), 32'(e.count));
                end
            end
            if (auto_ack) key_ack = 1'b1;
        end
        if (!key_valid) seen = 1'b0;
    end

    task automatic drain(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && fifo.size() == 0 && !key_valid && !key_ack) break;
        end
        check({tag, "_drained"}, 32'(exp_q.size() + fifo.size()), 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !key_valid; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(key_valid), 1);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        #1;
        exp_q.delete();
        fifo.delete();
        model_reset();
        check("clr_valid", 32'(key_valid), 0);
        check("clr_nextdata", 32'(nextdata_n), 1);
        check("clr_outs", {key_code, key_ascii, lut_addr, press_count}, 0);
        check("clr_flags", 32'({key_break, key_ext, shift, ctrl, caps, ovf_sticky}), 0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int p0;
        logic [7:0] c0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_nextdata", 32'(nextdata_n), 1);
        check("rst_outs", {key_code, key_ascii, lut_addr, press_count}, 0);
        check("rst_flags", 32'({key_break, key_ext, shift, ctrl, caps, ovf_sticky}), 0);
        clr = 1'b0;
        @(negedge clk);

        // Plain make/break.
        p0 = pops;
        send(8'h1c); send(8'hf0); send(8'h1c);
        drain("t1", 200);
        check("t1_pops", 32'(pops - p0), 3);
        check("t1_count", 32'(press_count), 1);

        // Shift affects case; release restores lowercase.
        send(8'h12); send(8'h1c); send(8'hf0); send(8'h12); send(8'h1c);
        drain("t2", 300);
        check("t2_shift", 32'(shift), 0);

        // Caps lock toggles on fresh makes only.
        send(8'h58); send(8'hf0); send(8'h58); send(8'h58); send(8'h1c);
        drain("t3", 300);
        check("t3_caps", 32'(caps), 0);

        // Auto-repeat counts once.
        c0 = press_count;
        send(8'h32); send(8'h32); send(8'h32);
        drain("t3b", 300);
        check("t3b_count", 32'(press_count - c0), 1);

        // Extended make, extended break, and redundant prefixes.
        send(8'he0); send(8'h75); send(8'he0); send(8'hf0); send(8'h75);
        send(8'he0); send(8'he0); send(8'h14); send(8'hf0); send(8'hf0); send(8'h14);
        drain("t4", 400);

        // Consumer stall: output held, no pops while waiting.
        auto_ack = 1'b0;
        send(8'h16);
        wait_valid("t5");
        send(8'h32); send(8'hf0); send(8'h32); send(8'h16);
        @(negedge clk);
        p0 = pops;
        repeat (20) @(negedge clk);
        check("t5_hold_valid", 32'(key_valid), 1);
        check("t5_hold_code", 32'(key_code), 32'h16);
        check("t5_hold_ascii", 32'(key_ascii), 32'h31);
        check("t5_hold_pops", 32'(pops - p0), 0);
        auto_ack = 1'b1;
        for (int i = 0; i < 10 && !key_ack; i++) begin
            @(negedge clk);
            #1;
        end
        check("t5_ack", 32'(key_ack), 1);
        @(negedge clk);
        #1;
        check("t5_valid_drop", 32'(key_valid), 0);
        drain("t5", 400);

        // Reset during LOOK.
        send(8'h1c);
        for (int i = 0; i < 50 && lut_addr != 8'h1c; i++) @(negedge clk);
        check("t6_in_look", 32'(lut_addr), 32'h1c);
        do_clear();

        // Reset during EMIT.
        auto_ack = 1'b0;
        send(8'h32);
        wait_valid("t7");
        @(negedge clk);
        do_clear();
        auto_ack = 1'b1;
        send(8'h1c);
        drain("t7", 200);
        check("t7_count", 32'(press_count), 1);

        // Sticky overflow.
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("t8_ovf_set", 32'(ovf_sticky), 1);
        do_clear();
        @(negedge clk);
        check("t8_ovf_cleared", 32'(ovf_sticky), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
